// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO accumulator.
//   HILO_DW      - default width of each of HI and LO
//   OP_*         - op_i encoding (3 bits)
//   hilo_state_e - control FSM states (IDLE accepts, ACC finishes an accumulate)
package hilo_pkg;

  localparam int HILO_DW = 32;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WR_HI   = 3'd1;
  localparam logic [2:0] OP_WR_LO   = 3'd2;
  localparam logic [2:0] OP_WR_BOTH = 3'd3;
  localparam logic [2:0] OP_MADD    = 3'd4;
  localparam logic [2:0] OP_MSUB    = 3'd5;
  localparam logic [2:0] OP_RSV6    = 3'd6;
  localparam logic [2:0] OP_RSV7    = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } hilo_state_e;

endpackage

// File: rtl/hilo_addsub.sv
// hilo_addsub: purely combinational W-bit unsigned add/subtract, modulo 2^W.
//   a   - minuend / first addend
//   b   - subtrahend / second addend
//   sub - 1: sum = a - b, 0: sum = a + b (carry/borrow discarded)
//   sum - result
module hilo_addsub #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  // select add or subtract; the result simply wraps at W bits
  always_comb begin
    sum = '0;
    if (sub) begin
      sum = a - b;
    end else begin
      sum = a + b;
    end
  end

endmodule

// File: rtl/hilo_acc.sv
// hilo_acc: HI/LO register pair with direct writes and a two-edge
// multiply-accumulate/subtract of an externally computed 2*DW product.
//   clk, rst        - clock (rising edge) and async active-high reset
//   valid_i, op_i   - request and operation (see hilo_pkg OP_*)
//   hi_i, lo_i      - write data, or upper/lower product half for MADD/MSUB
//   flush_i         - cancels an in-flight accumulate, blocks acceptance
//   ready_o, busy_o - FSM in IDLE / in ACC
//   hi_o, lo_o      - registered HI and LO
module hilo_acc
  import hilo_pkg::*;
#(
  parameter int DW = HILO_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  input  logic          flush_i,
  output logic          ready_o,
  output logic          busy_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  hilo_state_e     r_state;
  logic            r_ready;
  logic            r_busy;
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;
  logic [2*DW-1:0] r_prod;
  logic            r_sub;
  logic [2*DW-1:0] w_sum;
  logic            w_accept;

  // a request is taken only in IDLE and only when no flush is present
  assign w_accept = valid_i & (r_state == ST_IDLE) & ~flush_i;

  // the adder only ever sees registered operands, so hi_i/lo_i never
  // reach hi_o/lo_o combinationally
  hilo_addsub #(
    .W (2*DW)
  ) u_addsub (
    .a   ({r_hi, r_lo}),
    .b   (r_prod),
    .sub (r_sub),
    .sum (w_sum)
  );

  // control FSM with HI/LO, product capture and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_prod  <= '0;
      r_sub   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (op_i)
              OP_WR_HI:   r_hi <= hi_i;
              OP_WR_LO:   r_lo <= lo_i;
              OP_WR_BOTH: begin
                r_hi <= hi_i;
                r_lo <= lo_i;
              end
              OP_MADD, OP_MSUB: begin
                r_prod  <= {hi_i, lo_i};
                r_sub   <= (op_i == OP_MSUB);
                r_state <= ST_ACC;
                r_ready <= 1'b0;
                r_busy  <= 1'b1;
              end
              OP_NOP, OP_RSV6, OP_RSV7: begin
                r_state <= ST_IDLE;
              end
              default: begin
                r_state <= ST_IDLE;
              end
            endcase
          end
        end
        ST_ACC: begin
          // a flush abandons the accumulate; otherwise commit the sum
          if (!flush_i) begin
            r_hi <= w_sum[2*DW-1:DW];
            r_lo <= w_sum[DW-1:0];
          end
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign busy_o  = r_busy;
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;

endmodule

// File: tb/tb_hilo_acc.sv
// tb_hilo_acc: self-checking bench for hilo_acc. A transaction-level model
// (one 64-bit HI:LO value plus a pending-product slot) is compared with the
// DUT after every edge; directed literal checks pin the model itself, then
// randomized traffic exercises ops, flushes, stalls and resets.
module tb_hilo_acc;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic [2:0]    op_i;
  logic [DW-1:0] hi_i;
  logic [DW-1:0] lo_i;
  logic          flush_i;
  logic          ready_o;
  logic          busy_o;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // behavioural model state
  bit [2*DW-1:0] m_val  = '0;
  bit            m_pend = 1'b0;
  bit [2*DW-1:0] m_prod = '0;
  bit            m_sub  = 1'b0;

  hilo_acc #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .op_i    (op_i),
    .hi_i    (hi_i),
    .lo_i    (lo_i),
    .flush_i (flush_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: whole HI:LO as one number, an accumulate takes one extra edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val  = '0;
      m_pend = 1'b0;
      m_prod = '0;
      m_sub  = 1'b0;
    end else if (m_pend) begin
      if (!flush_i) m_val = m_sub ? (m_val - m_prod) : (m_val + m_prod);
      m_pend = 1'b0;
    end else if (valid_i && !flush_i) begin
      case (op_i)
        3'd1: m_val[63:32] = hi_i;
        3'd2: m_val[31:0]  = lo_i;
        3'd3: m_val        = {hi_i, lo_i};
        3'd4, 3'd5: begin
          m_prod = {hi_i, lo_i};
          m_sub  = (op_i == 3'd5);
          m_pend = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // compare DUT with model shortly after every rising edge
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_hilo",  {hi_o, lo_o}, m_val);
      check("model_ready", {63'd0, ready_o}, {63'd0, !m_pend});
      check("model_busy",  {63'd0, busy_o},  {63'd0, m_pend});
    end
  end

  // present one request at a negedge, hold it until taken; returns edges spent
  task automatic send(input logic [2:0] op, input logic [31:0] h, input logic [31:0] l,
                      output int edges);
    bit done;
    done  = 1'b0;
    edges = 0;
    valid_i = 1'b1;
    op_i    = op;
    hi_i    = h;
    lo_i    = l;
    for (int k = 0; k < 8 && !done; k++) begin
      done = ready_o;
      @(negedge clk);
      edges++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: op %0d not accepted within 8 cycles", op);
    end
    valid_i = 1'b0;
    op_i    = 3'd0;
    hi_i    = $urandom;
    lo_i    = $urandom;
  endtask

  int e;
  int e2;
  logic [63:0] snap;

  initial begin
    rst = 1'b1; valid_i = 1'b0; op_i = 3'd0; hi_i = '0; lo_i = '0; flush_i = 1'b0;
    // requests presented during reset must be ignored
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd3; hi_i = 32'hDEADBEEF; lo_i = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_hilo",  {hi_o, lo_o}, 64'd0);
    check("rst_ready", {63'd0, ready_o}, 64'd1);
    check("rst_busy",  {63'd0, busy_o}, 64'd0);
    valid_i = 1'b0;
    rst = 1'b0;
    chk_en = 1'b1;

    // direct writes
    send(3'd3, 32'h12345678, 32'h9ABCDEF0, e);
    check("wr_both_lat", e, 1);
    check("wr_both", {hi_o, lo_o}, 64'h12345678_9ABCDEF0);
    send(3'd2, 32'hFFFFFFFF, 32'h00000001, e);
    check("wr_lo", {hi_o, lo_o}, 64'h12345678_00000001);
    send(3'd1, 32'hA5A5A5A5, 32'h0, e);
    check("wr_hi", {hi_o, lo_o}, 64'hA5A5A5A5_00000001);

    // MADD carry from LO into HI
    send(3'd3, 32'h0, 32'hFFFFFFFF, e);
    send(3'd4, 32'h0, 32'h1, e);
    check("madd_busy",  {63'd0, busy_o}, 64'd1);
    check("madd_ready", {63'd0, ready_o}, 64'd0);
    check("madd_hold",  {hi_o, lo_o}, 64'h00000000_FFFFFFFF);
    @(negedge clk);
    check("madd_carry", {hi_o, lo_o}, 64'h00000001_00000000);
    check("madd_ready_back", {63'd0, ready_o}, 64'd1);

    // wrap both ways
    send(3'd3, 32'h0, 32'h0, e);
    send(3'd5, 32'h0, 32'h1, e);
    @(negedge clk);
    check("msub_wrap", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFF);
    send(3'd4, 32'h0, 32'h1, e);
    @(negedge clk);
    check("madd_wrap", {hi_o, lo_o}, 64'd0);

    // back-to-back MADD with valid held: second taken 2 edges after first
    send(3'd4, 32'h00000002, 32'h00000005, e);
    send(3'd4, 32'h00000001, 32'hFFFFFFFF, e2);
    check("b2b_spacing", e2, 2);
    @(negedge clk);
    check("b2b_sum", {hi_o, lo_o}, 64'h00000004_00000004);

    // flush during ACC keeps HI:LO
    send(3'd3, 32'h11112222, 32'h33334444, e);
    send(3'd4, 32'h0, 32'h10, e);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_acc_hilo",  {hi_o, lo_o}, 64'h11112222_33334444);
    check("flush_acc_ready", {63'd0, ready_o}, 64'd1);

    // reset pulse during ACC clears immediately
    send(3'd5, 32'h0, 32'h3, e);
    rst = 1'b1;
    #1;
    check("rst_acc_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_acc_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_acc_after", {hi_o, lo_o}, 64'd0);

    // reserved ops and flushed requests change nothing
    send(3'd3, 32'h0BADF00D, 32'h600DCAFE, e);
    send(3'd6, $urandom, $urandom, e);
    send(3'd7, $urandom, $urandom, e);
    send(3'd0, $urandom, $urandom, e);
    check("rsv_ops", {hi_o, lo_o}, 64'h0BADF00D_600DCAFE);
    for (int k = 0; k < 8; k++) begin
      flush_i = 1'b1; valid_i = 1'b1; op_i = k[2:0]; hi_i = $urandom; lo_i = $urandom;
      @(negedge clk);
    end
    flush_i = 1'b0; valid_i = 1'b0;
    check("flush_idle", {hi_o, lo_o}, 64'h0BADF00D_600DCAFE);
    check("flush_idle_ready", {63'd0, ready_o}, 64'd1);

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      op_i    = 3'($urandom_range(0, 7));
      hi_i    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      lo_i    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      flush_i = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
